cfb_dec: RTL and testbench



---
 rtl/aes_mode_pkg.sv | 11 +
 rtl/cfb_dec_if.sv | 37 +++
 rtl/core.sv | 112 +++++++++++
 rtl/cfb_dec.sv | 90 +++++++++
 tb/tb_cfb_dec.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_mode_pkg.sv
// aes_mode_pkg: constants and types shared by the AES block-mode wrappers.
package aes_mode_pkg;
    localparam int BLOCK_W = 128;

    typedef enum logic [1:0] {
        IDLE,
        KEY_EXPANSION,
        RUNNING,
        HOLD
    } cfb_dec_state_t;
endpackage

// File: rtl/cfb_dec_if.sv
// cfb_dec_if: key/IV load, ciphertext-in and plaintext-out streams of cfb_dec.
// The blk_cnt signal exists only when CFB_DEC_BLKCNT_EN is defined.
interface cfb_dec_if;
    import aes_mode_pkg::*;

    logic               load;
    logic [BLOCK_W-1:0] key;
    logic [BLOCK_W-1:0] iv;
    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [BLOCK_W-1:0] out_data;
    logic               idle;
`ifdef CFB_DEC_BLKCNT_EN
    logic [31:0]        blk_cnt;

    modport master (
        output load, key, iv, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, idle, blk_cnt
    );
    modport slave (
        input  load, key, iv, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, idle, blk_cnt
    );
`else
    modport master (
        output load, key, iv, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, idle
    );
    modport slave (
        input  load, key, iv, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, idle
    );
`endif
endinterface

// File: rtl/core.sv
// core: iterative AES-128 forward cipher, one round per clock, round keys derived on the fly.
// load latches the key; start encrypts iBlock; oBlock is valid whenever idle is high.
module core (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] iBlock,
    output logic [127:0] oBlock,
    output logic         idle
);
    logic [127:0] key_q, st_q, rk_q, nrk;
    logic [7:0]   rc_q;
    logic [3:0]   rnd_q;
    logic         idle_q;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc, x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    // Inverse as x^254 (product of x^2..x^128), then the affine map; 0 maps to 0x63.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p, v;
        p = x;
        v = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gmul(p, p);
            v = gmul(v, p);
        end
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] next_rk(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [127:0] sub, sh, mix;
        logic [7:0]   a0, a1, a2, a3;
        for (int i = 0; i < 16; i++) sub[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sh[127-8*(r+4*c) -: 8] = sub[127-8*(r+4*((c+r)%4)) -: 8];
        for (int c = 0; c < 4; c++) begin
            a0 = sh[127-32*c -: 8];
            a1 = sh[119-32*c -: 8];
            a2 = sh[111-32*c -: 8];
            a3 = sh[103-32*c -: 8];
            mix[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                   a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                   a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                   xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return (last ? sh : mix) ^ rk;
    endfunction

    assign nrk    = next_rk(rk_q, rc_q);
    assign oBlock = st_q;
    assign idle   = idle_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q  <= '0;
            st_q   <= '0;
            rk_q   <= '0;
            rc_q   <= 8'h00;
            rnd_q  <= 4'd0;
            idle_q <= 1'b1;
        end else if (idle_q && load) begin
            key_q  <= key;
            rnd_q  <= 4'd0;
            idle_q <= 1'b0;
        end else if (idle_q && start) begin
            st_q   <= iBlock ^ key_q;
            rk_q   <= key_q;
            rc_q   <= 8'h01;
            rnd_q  <= 4'd1;
            idle_q <= 1'b0;
        end else if (!idle_q) begin
            // Round 0 marks the single busy cycle spent latching a new key.
            if (rnd_q == 4'd0) begin
                idle_q <= 1'b1;
            end else begin
                st_q <= aes_round(st_q, nrk, rnd_q == 4'd10);
                rk_q <= nrk;
                rc_q <= xtime(rc_q);
                if (rnd_q == 4'd10) idle_q <= 1'b1;
                else                rnd_q  <= rnd_q + 4'd1;
            end
        end
    end
endmodule

// File: rtl/cfb_dec.sv
// cfb_dec: CFB-128 decryption, P_i = E_K(C_{i-1}) ^ C_i with C_0 = IV, one block in flight.
// Defining CFB_DEC_BLKCNT_EN adds the 32-bit blk_cnt output.
module cfb_dec
    import aes_mode_pkg::*;
(
    input logic      clk,
    input logic      rst,
    cfb_dec_if.slave bus
);
    cfb_dec_state_t     state_q;
    logic [BLOCK_W-1:0] fb_q, c_q, out_q, core_out;
    logic               keyed_q, out_valid_q;
    logic               core_idle, core_load, accept;
`ifdef CFB_DEC_BLKCNT_EN
    logic [31:0]        blk_cnt_q;

    assign bus.blk_cnt = blk_cnt_q;
`endif

    // A load request blocks acceptance in the same cycle, so load always wins.
    assign bus.in_ready  = (state_q == IDLE) && keyed_q && !bus.load;
    assign accept        = bus.in_valid && bus.in_ready;
    assign core_load     = (state_q == IDLE) && bus.load;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_q;
    assign bus.idle      = (state_q == IDLE) && !out_valid_q;

    core u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (core_load),
        .start  (accept),
        .key    (bus.key),
        .iBlock (fb_q),
        .oBlock (core_out),
        .idle   (core_idle)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            keyed_q     <= 1'b0;
            fb_q        <= '0;
            c_q         <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
`ifdef CFB_DEC_BLKCNT_EN
            blk_cnt_q   <= 32'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.load) begin
                        fb_q    <= bus.iv;
                        keyed_q <= 1'b1;
`ifdef CFB_DEC_BLKCNT_EN
                        blk_cnt_q <= 32'd0;
`endif
                        state_q <= KEY_EXPANSION;
                    end else if (accept) begin
                        c_q     <= bus.in_data;
                        state_q <= RUNNING;
                    end
                end
                KEY_EXPANSION: begin
                    if (core_idle) state_q <= IDLE;
                end
                RUNNING: begin
                    // Feedback is the received ciphertext, not the cipher output.
                    if (core_idle) begin
                        out_q       <= core_out ^ c_q;
                        fb_q        <= c_q;
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
`ifdef CFB_DEC_BLKCNT_EN
                        blk_cnt_q   <= blk_cnt_q + 32'd1;
`endif
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cfb_dec.sv
// tb_cfb_dec: NIST vectors, corner sequences and random chains against a byte-level AES/CFB model.
module tb_cfb_dec;
    import aes_mode_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cfb_dec_if bus();
    cfb_dec dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        logic [127:0] c;
        logic [127:0] p;
    } vec_t;

    localparam logic [127:0] NIST_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] NIST_IV  = 128'h000102030405060708090a0b0c0d0e0f;

    vec_t         vecs [4];
    int           total = 0;
    int           bad   = 0;
    logic [7:0]   sb [256];
    logic [127:0] m_key, m_fb;
    logic [31:0]  m_cnt;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] dbl(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input int cf, input logic [7:0] a);
        if (cf == 2) return dbl(a);
        if (cf == 3) return dbl(a) ^ a;
        return a;
    endfunction

    // S-box built by walking the multiplicative group with generator 3.
    task automatic build_sbox;
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [127:0] ref_aes(input logic [127:0] k, input logic [127:0] pt);
        logic [7:0]   w [44][4];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   tmp [4];
        logic [7:0]   rc, x;
        logic [127:0] o;
        int           coef [4];
        coef = '{2, 3, 1, 1};
        rc = 8'h01;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) w[i][j] = k[127-8*(4*i+j) -: 8];
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i-1][j];
            if (i % 4 == 0) begin
                x = tmp[0];
                for (int j = 0; j < 3; j++) tmp[j] = sb[tmp[j+1]];
                tmp[3] = sb[x];
                tmp[0] = tmp[0] ^ rc;
                rc = dbl(rc);
            end
            for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][i%4];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) begin
                    if (rnd == 10) x = t[r+4*c];
                    else begin
                        x = 8'h00;
                        for (int kk = 0; kk < 4; kk++) x = x ^ gm(coef[(kk-r+4)%4], t[kk+4*c]);
                    end
                    s[r+4*c] = x ^ w[4*rnd+c][r];
                end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    task automatic model_step(input logic [127:0] c, output logic [127:0] p);
        p     = ref_aes(m_key, m_fb) ^ c;
        m_fb  = c;
        m_cnt = m_cnt + 32'd1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!bus.in_ready && n < 100) begin
            tick();
            n++;
        end
        chk($sformatf("%s_in_ready", name), bus.in_ready, 1'b1);
    endtask

    task automatic do_load(input logic [127:0] k, input logic [127:0] iv);
        bus.load = 1'b1;
        bus.key  = k;
        bus.iv   = iv;
        tick();
        bus.load = 1'b0;
        m_key = k;
        m_fb  = iv;
        m_cnt = 32'd0;
        wait_ready("load");
    endtask

    task automatic send_block(input logic [127:0] c, input int stall, input string name);
        logic [127:0] exp_p, held;
        int n;
        model_step(c, exp_p);
        bus.out_ready = (stall == 0);
        bus.in_valid  = 1'b1;
        bus.in_data   = c;
        wait_ready(name);
        tick();
        bus.in_valid = 1'b0;
        chk($sformatf("%s_busy", name), {bus.in_ready, bus.idle}, 2'b00);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            tick();
            n++;
        end
        chk($sformatf("%s_out_valid", name), bus.out_valid, 1'b1);
        chk($sformatf("%s_data", name), bus.out_data, exp_p);
        held = bus.out_data;
        for (int i = 0; i < stall; i++) begin
            tick();
            chk($sformatf("%s_hold", name), {bus.out_valid, bus.in_ready, bus.out_data},
                {1'b1, 1'b0, held});
        end
        bus.out_ready = 1'b1;
        tick();
        chk($sformatf("%s_one_shot", name), {bus.out_valid, bus.out_data}, {1'b0, exp_p});
`ifdef CFB_DEC_BLKCNT_EN
        chk($sformatf("%s_blk_cnt", name), bus.blk_cnt, m_cnt);
`endif
        tick();
        chk($sformatf("%s_no_second", name), bus.out_valid, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{128'h3b3fd92eb72dad20333449f8e83cfb4a, 128'h6bc1bee22e409f96e93d7e117393172a};
        vecs[1] = '{128'hc8a64537a0b3a93fcde3cdad9f1ce58b, 128'hae2d8a571e03ac9c9eb76fac45af8e51};
        vecs[2] = '{128'h26751f67a3cbb140b1808cf187a4f4df, 128'h30c81c46a35ce411e5fbc1191a0a52ef};
        vecs[3] = '{128'hc04b05357c5d1c0eeac4c66f9ff7f2e6, 128'hf69f2445df4f9b17ad2b417be66c3710};
        bus.load = 1'b0; bus.key = '0; bus.iv = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
        m_key = '0; m_fb = '0; m_cnt = 32'd0;
        build_sbox();

        repeat (3) tick();
        chk("reset_state", {bus.out_valid, bus.in_ready, bus.idle, bus.out_data},
            {1'b0, 1'b0, 1'b1, 128'h0});
`ifdef CFB_DEC_BLKCNT_EN
        chk("reset_blk_cnt", bus.blk_cnt, 32'd0);
`endif
        rst = 1'b0;
        tick();

        chk("model_sbox", {sb[8'h00], sb[8'h01], sb[8'h53]}, 24'h637ced);
        chk("model_fips197", ref_aes(NIST_IV, 128'h00112233445566778899aabbccddeeff),
            128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        // No key yet: a presented block must be ignored entirely.
        bus.in_valid = 1'b1;
        bus.in_data  = vecs[0].c;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("preload_ignored", {bus.in_ready, bus.idle, bus.out_valid}, 3'b010);
        end
        bus.in_valid = 1'b0;

        do_load(NIST_KEY, NIST_IV);
        for (int i = 0; i < 4; i++) begin
            send_block(vecs[i].c, 0, "vec");
            chk($sformatf("vec%0d_table", i), bus.out_data, vecs[i].p);
        end

        do_load(NIST_KEY, NIST_IV);
        send_block(vecs[0].c, 20, "bp");
        chk("bp_table", bus.out_data, vecs[0].p);

        // Load and a block arrive together mid-stream: the load wins, block dropped.
        bus.load     = 1'b1;
        bus.key      = NIST_KEY;
        bus.iv       = NIST_IV;
        bus.in_valid = 1'b1;
        bus.in_data  = vecs[2].c;
        #1;
        chk("coll_ready", bus.in_ready, 1'b0);
        tick();
        bus.load = 1'b0;
        chk("coll_keyexp", {bus.in_ready, bus.idle}, 2'b00);
        tick();
        bus.in_valid = 1'b0;
        m_key = NIST_KEY;
        m_fb  = NIST_IV;
        m_cnt = 32'd0;
        send_block(vecs[0].c, 0, "coll");
        chk("coll_table", bus.out_data, vecs[0].p);

        for (int k = 0; k < 3; k++) begin
            do_load({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
            for (int j = 0; j < 6; j++)
                send_block({$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3), "rnd");
        end

        // Reset while a block is in the cipher: nothing may come out.
        bus.in_valid = 1'b1;
        bus.in_data  = vecs[1].c;
        wait_ready("rstrun");
        tick();
        bus.in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk("rst_async", {bus.out_valid, bus.idle, bus.in_ready}, 3'b010);
        tick();
        rst = 1'b0;
`ifdef CFB_DEC_BLKCNT_EN
        chk("rst_blk_cnt", bus.blk_cnt, 32'd0);
`endif
        bus.in_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("rst_quiet", {bus.out_valid, bus.idle, bus.in_ready}, 3'b010);
        end
        bus.in_valid = 1'b0;
        do_load(NIST_KEY, NIST_IV);
        send_block(vecs[0].c, 0, "after_rst");
        chk("after_rst_table", bus.out_data, vecs[0].p);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
